axi_i2s_lite_regs: RTL and testbench
====================================

// Module: axi_i2s_lite_regs
// PURPOSE
//  AXI4-Lite slave register bank sitting directly downstream of the AXI4-Lite master
//  BFM (S00_AXI port) in the axi_i2s_adi block design.
//  Terminates the S00_AXI channel and provides four 32-bit read/write control words.
//  The I2S core consumes these words through reg_out, plus a per-register write strobe.
//  Supports AW/W arriving in any order, byte strobes, and back-pressure on B and R.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  32  address bus width; only bits [3:2] decoded
//  C_RESET_VALUE       0   reset value of all four registers
// PORTS
//  ACLK            in   1    clock; all logic on rising edge
//  ARESETN         in   1    asynchronous active-low reset
//  S_AXI_AWADDR    in   32   write address
//  S_AXI_AWPROT    in   3    ignored
//  S_AXI_AWVALID   in   1    write address valid
//  S_AXI_AWREADY   out  1    write address ready
//  S_AXI_WDATA     in   32   write data
//  S_AXI_WSTRB     in   4    byte enables; bit i covers WDATA[8i+7:8i]
//  S_AXI_WVALID    in   1    write data valid
//  S_AXI_WREADY    out  1    write data ready
//  S_AXI_BRESP     out  2    always 2'b00 (OKAY)
//  S_AXI_BVALID    out  1    write response valid
//  S_AXI_BREADY    in   1    write response ready
//  S_AXI_ARADDR    in   32   read address
//  S_AXI_ARPROT    in   3    ignored
//  S_AXI_ARVALID   in   1    read address valid
//  S_AXI_ARREADY   out  1    read address ready
//  S_AXI_RDATA     out  32   read data
//  S_AXI_RRESP     out  2    always 2'b00 (OKAY)
//  S_AXI_RVALID    out  1    read data valid
//  S_AXI_RREADY    in   1    read data ready
//  reg_out         out  128  {reg3,reg2,reg1,reg0}
//  reg_wr_pulse    out  4    one-cycle pulse, bit n = register n written
// BEHAVIOUR
//  Reset (ARESETN low, async):
//   - All readies, BVALID, RVALID, RDATA and reg_wr_pulse are 0.
//   - All registers = C_RESET_VALUE; AW/W holding flags cleared.
//  Ready generation (registered):
//   - AWREADY = !aw_held & !BVALID; WREADY = !w_held & !BVALID.
//   - Both rise on the first edge after reset release.
//  Write path:
//   - Handshake at edge N latches AWADDR[3:2] (sets aw_held) or WDATA/WSTRB (sets w_held).
//   - AW and W may complete in the same cycle or in either order, any gap.
//   - Commit at the edge after both flags are set:
//     - write only the strobed bytes of reg[addr[3:2]];
//     - set BVALID; pulse reg_wr_pulse[n] for that one cycle;
//     - clear aw_held and w_held.
//   - WSTRB = 0 still commits and pulses, but changes no data.
//   - BVALID holds until BREADY is sampled high; readies stay low meanwhile.
//   - Back-to-back writes: at most one outstanding write.
//  Read path:
//   - ARREADY = !RVALID (registered).
//   - On the AR handshake edge: RDATA <= reg[ARADDR[3:2]], RVALID <= 1 (1-cycle latency).
//   - RDATA and RVALID hold stable until RREADY; ARREADY returns high the cycle after.
//  Address decode:
//   - Bits [1:0] and bits above [3] ignored; addresses alias modulo 16 bytes.
//   - No error responses.
//  Simultaneous read/write:
//   - Channels are independent.
//   - If a write commit and an AR handshake to the same register share an edge,
//     RDATA returns the pre-write value.
//  Mid-transaction reset:
//   - Pending AW/W, BVALID and RVALID are dropped immediately.
//   - Registers return to reset value; no partial write is performed.
// TESTING
//  1. Write 0x0101FFFF @0x0, AW+W same cycle, BREADY=1:
//     BVALID 2 edges later, BRESP=0, reg_wr_pulse=4'b0001; read @0x0 -> 0x0101FFFF, RRESP=0.
//  2. W first (0xabcd0001), AW @0x4 three cycles later:
//     commit the edge after AW; reg1=0xabcd0001; reg0 unchanged.
//  3. Write 0xdead0011 @0x8 with WSTRB=4'b0011 over reg2=0:
//     reg2=0x00000011; then a full write of 0xbeef0011 @0xC; read @0x1C -> 0xbeef0011 (alias).
//  4. Hold BREADY/RREADY low 5 cycles:
//     BVALID/RVALID and RDATA stable; AWREADY/WREADY/ARREADY low throughout; second AW not accepted.
//  5. AR @0x4 on the same edge as a write commit of 0x12345678 to reg1 (old 0xabcd0001):
//     RDATA=0xabcd0001; next read -> 0x12345678.
//  6. Assert ARESETN low with aw_held set and RVALID high:
//     all outputs 0 asynchronously; regs=C_RESET_VALUE; after release, a fresh write completes normally.

Source files
------------

// File: rtl/axi_i2s_lite_regs_if.sv
// AXI4-Lite bus bundle between the S00_AXI master and the I2S control register bank.
// The slave modport is the register-bank side and the master modport is the BFM side.
interface axi_i2s_lite_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_i2s_lite_regs.sv
// AXI4-Lite slave holding four 32-bit I2S control words, exported on reg_out
// together with a one-cycle write strobe for each register.
module axi_i2s_lite_regs #(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RESET_VALUE      = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    axi_i2s_lite_regs_if.slave              s_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [3:0]                      reg_wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    logic [DW-1:0] regs [4];

    logic          aw_held;
    logic          w_held;
    logic [1:0]    aw_idx;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic b_done;
    logic r_done;
    logic aw_held_nxt;
    logic w_held_nxt;
    logic bvalid_nxt;
    logic rvalid_nxt;

    // A write commits the edge after both the address and the data have been captured.
    always_comb begin
        aw_hs  = s_axi.awvalid & s_axi.awready;
        w_hs   = s_axi.wvalid & s_axi.wready;
        ar_hs  = s_axi.arvalid & s_axi.arready;
        commit = aw_held & w_held;
        b_done = s_axi.bvalid & s_axi.bready;
        r_done = s_axi.rvalid & s_axi.rready;

        aw_held_nxt = aw_held;
        if (commit)
            aw_held_nxt = 1'b0;
        else if (aw_hs)
            aw_held_nxt = 1'b1;

        w_held_nxt = w_held;
        if (commit)
            w_held_nxt = 1'b0;
        else if (w_hs)
            w_held_nxt = 1'b1;

        bvalid_nxt = s_axi.bvalid;
        if (commit)
            bvalid_nxt = 1'b1;
        else if (b_done)
            bvalid_nxt = 1'b0;

        rvalid_nxt = s_axi.rvalid;
        if (ar_hs)
            rvalid_nxt = 1'b1;
        else if (r_done)
            rvalid_nxt = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= 2'd0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            reg_wr_pulse  <= 4'd0;
        end else begin
            aw_held <= aw_held_nxt;
            w_held  <= w_held_nxt;
            if (aw_hs)
                aw_idx <= s_axi.awaddr[3:2];
            if (w_hs) begin
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            s_axi.bvalid  <= bvalid_nxt;
            // Readies are computed from next state so they never overlap a held beat or a pending response.
            s_axi.awready <= !aw_held_nxt && !bvalid_nxt;
            s_axi.wready  <= !w_held_nxt && !bvalid_nxt;
            reg_wr_pulse  <= commit ? (4'(1) << aw_idx) : 4'd0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int r = 0; r < 4; r++)
                regs[r] <= C_RESET_VALUE;
        end else if (commit) begin
            for (int b = 0; b < SW; b++)
                if (w_strb[b])
                    regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    // The read samples regs before this edge's commit lands, so a colliding read sees the old word.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
        end else begin
            if (ar_hs)
                s_axi.rdata <= regs[s_axi.araddr[3:2]];
            s_axi.rvalid  <= rvalid_nxt;
            s_axi.arready <= !rvalid_nxt;
        end
    end

    assign s_axi.bresp = 2'b00;
    assign s_axi.rresp = 2'b00;
    assign reg_out     = {regs[3], regs[2], regs[1], regs[0]};

    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:4], s_axi.awaddr[1:0],
                         s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:4], s_axi.araddr[1:0]};
endmodule

// File: tb/tb_axi_i2s_lite_regs.sv
// Self-checking bench for axi_i2s_lite_regs: directed scenarios followed by random
// traffic, all checked against a word-level register model.
module tb_axi_i2s_lite_regs;
    logic         ACLK;
    logic         ARESETN;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_pulse;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [4];

    axi_i2s_lite_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_i2s_lite_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_RESET_VALUE     (32'h0)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .s_axi       (bus.slave),
        .reg_out     (reg_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int reg_index(input logic [31:0] addr);
        return int'(addr % 32'd16) / 4;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                               input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++)
            if (strb[i]) mask = mask | (32'hFF << (8 * i));
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
    endtask

    task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly, input int b_dly);
        int   c;
        int   idx;
        bit   aw_done;
        bit   w_done;
        logic aw_rdy;
        logic w_rdy;
        c = 0;
        aw_done = 1'b0;
        w_done = 1'b0;
        idx = reg_index(addr);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        while (!(aw_done && w_done) && c < 40) begin
            bus.awvalid = !aw_done && (c >= aw_dly);
            bus.wvalid  = !w_done && (c >= w_dly);
            aw_rdy = bus.awready;
            w_rdy  = bus.wready;
            tick();
            if (bus.awvalid && aw_rdy) aw_done = 1'b1;
            if (bus.wvalid && w_rdy) w_done = 1'b1;
            c++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check_output("wr_handshake", {aw_done, w_done}, 2'b11);
        check_output("b_not_early", {bus.bvalid, reg_wr_pulse}, 5'b0);
        tick();
        check_output("b_commit", {bus.bvalid, bus.bresp, reg_wr_pulse}, {1'b1, 2'b00, 4'(1 << idx)});
        model[idx] = byte_merge(model[idx], data, strb);
        check_output("reg_out_after_wr", reg_out, model_flat());
        for (int k = 0; k < b_dly; k++) begin
            tick();
            check_output("b_hold", {bus.bvalid, reg_wr_pulse, bus.awready, bus.wready}, 7'b1_0000_00);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check_output("b_release", {bus.bvalid, reg_wr_pulse, bus.awready, bus.wready}, 7'b0_0000_11);
    endtask

    task automatic apply_read(input logic [31:0] addr, input int r_dly);
        int          c;
        logic        rdy;
        logic [31:0] expected;
        logic [31:0] first_data;
        expected = model[reg_index(addr)];
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        c = 0;
        rdy = 1'b0;
        while (!rdy && c < 20) begin
            rdy = bus.arready;
            tick();
            c++;
        end
        bus.arvalid = 1'b0;
        check_output("ar_handshake", rdy, 1'b1);
        check_output("r_data", {bus.rvalid, bus.rresp, bus.arready, bus.rdata}, {1'b1, 2'b00, 1'b0, expected});
        first_data = bus.rdata;
        for (int k = 0; k < r_dly; k++) begin
            tick();
            check_output("r_hold", {bus.rvalid, bus.arready, bus.rdata}, {1'b1, 1'b0, first_data});
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check_output("r_release", {bus.rvalid, bus.arready}, 2'b01);
    endtask

    initial begin
        logic [31:0] old_word;
        logic [31:0] rdata_first;

        ARESETN     = 1'b0;
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        model_reset();

        #3;
        check_output("reset_outputs",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata, reg_wr_pulse},
                     41'h0);
        check_output("reset_regs", reg_out, 128'h0);
        tick();
        tick();
        ARESETN = 1'b1;
        check_output("ready_before_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
        tick();
        check_output("ready_after_release", {bus.awready, bus.wready, bus.arready}, 3'b111);

        $display("[TB] scenario 1: AW and W together");
        apply_write(32'h0, 32'h0101FFFF, 4'hF, 0, 0, 0);
        apply_read(32'h0, 0);
        check_output("t1_reg0", reg_out[31:0], 32'h0101FFFF);

        $display("[TB] scenario 2: W leads AW by three cycles");
        apply_write(32'h4, 32'hABCD0001, 4'hF, 3, 0, 0);
        check_output("t2_regs", reg_out[63:0], {32'hABCD0001, 32'h0101FFFF});

        $display("[TB] scenario 3: partial strobes and aliasing");
        apply_write(32'h8, 32'hDEAD0011, 4'b0011, 0, 0, 0);
        check_output("t3_reg2", reg_out[95:64], 32'h00000011);
        apply_write(32'hC, 32'hBEEF0011, 4'hF, 1, 0, 1);
        apply_read(32'h1C, 0);
        check_output("t3_reg3", reg_out[127:96], 32'hBEEF0011);

        $display("[TB] scenario 4: back-pressure on B and R");
        bus.araddr  = 32'h4;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check_output("t4_r", {bus.rvalid, bus.rdata}, {1'b1, model[1]});
        rdata_first = bus.rdata;
        bus.awaddr  = 32'hC;
        bus.wdata   = 32'h0BADF00D;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        tick();
        model[3] = 32'h0BADF00D;
        check_output("t4_b", {bus.bvalid, reg_wr_pulse}, 5'b1_1000);
        bus.awaddr  = 32'h0;
        bus.wdata   = 32'h55555555;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output("t4_hold",
                         {bus.bvalid, bus.rvalid, bus.rdata, bus.awready, bus.wready, bus.arready, reg_wr_pulse},
                         {1'b1, 1'b1, rdata_first, 3'b000, 4'b0000});
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.rready  = 1'b1;
        tick();
        bus.bready  = 1'b0;
        bus.rready  = 1'b0;
        check_output("t4_release", {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, 5'b00111);
        check_output("t4_regs", reg_out, model_flat());

        $display("[TB] scenario 5: read colliding with a commit");
        old_word    = model[1];
        bus.awaddr  = 32'h4;
        bus.wdata   = 32'h12345678;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.araddr  = 32'h4;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check_output("t5_collide", {bus.bvalid, reg_wr_pulse, bus.rvalid, bus.rdata},
                     {1'b1, 4'b0010, 1'b1, 32'hABCD0001});
        check_output("t5_old_model", bus.rdata, old_word);
        model[1] = 32'h12345678;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        apply_read(32'h4, 1);

        $display("[TB] scenario 6: reset during a transaction");
        bus.awaddr  = 32'h8;
        bus.awvalid = 1'b1;
        bus.araddr  = 32'h0;
        bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        check_output("t6_pending", {bus.awready, bus.wready, bus.rvalid}, 3'b011);
        #2;
        ARESETN = 1'b0;
        #1;
        check_output("t6_async_outputs",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata, reg_wr_pulse},
                     41'h0);
        check_output("t6_async_regs", reg_out, 128'h0);
        model_reset();
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        check_output("t6_ready_back", {bus.awready, bus.wready, bus.arready}, 3'b111);
        apply_write(32'h8, 32'hCAFE1234, 4'hF, 2, 0, 0);
        apply_read(32'h8, 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 30; n++) begin
            apply_write($urandom, $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            apply_read($urandom, $urandom_range(0, 2));
        end
        check_output("final_regs", reg_out, model_flat());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
